pll_reset_seq: RTL and testbench
================================

PLL_RESET_SEQ -- requirements
Module: pll_reset_seq

Interface
REQ-001 Parameter SYNC_STAGES, default 2: number of flops in the pll_locked synchronizer (minimum 2).
REQ-002 Parameter LOCK_FILTER, default 16: consecutive synchronized-high cycles required to accept lock.
REQ-003 Parameter LOSS_FILTER, default 4: consecutive synchronized-low cycles in RUN required to declare lock loss.
REQ-004 Parameter HOLD_CYCLES, default 1024: cycles both resets stay asserted after lock is accepted.
REQ-005 Parameter STAGGER_CYCLES, default 64: cycles between sdram_reset release and sys_reset release.
REQ-006 clk  input  1  system clock, the 50 MHz 0-degree PLL output; one clock only.
REQ-007 reset  input  1  synchronous, active-high reset.
REQ-008 pll_locked  input  1  PLL lock flag, asynchronous to clk.
REQ-009 sdram_reset  output  1  active-high reset for the SDRAM controller and PHY, registered.
REQ-010 sys_reset  output  1  active-high reset for CPU and peripherals, registered.
REQ-011 ready  output  1  high only in RUN, registered.
REQ-012 loss_count  output  8  saturating count of lock-loss events; present only with PLL_RESET_LOSS_CNT_EN.

Function
REQ-013 pll_locked SHALL pass through SYNC_STAGES flops; all later logic SHALL use only the last stage (lock_s).
REQ-014 The FSM SHALL have exactly four states: WAIT_LOCK, HOLD, STAGGER, RUN.
REQ-015 WAIT_LOCK: both resets at 1, ready at 0; the counter increments while lock_s=1 and clears when lock_s=0; on reaching LOCK_FILTER the FSM goes to HOLD with the counter cleared.
REQ-016 HOLD: both resets at 1; the FSM counts HOLD_CYCLES, then goes to STAGGER, and sdram_reset falls on the same edge.
REQ-017 STAGGER: sdram_reset at 0, sys_reset at 1; the FSM counts STAGGER_CYCLES, then goes to RUN, with sys_reset falling and ready rising on the same edge.
REQ-018 RUN: the FSM counts consecutive lock_s=0 cycles; on reaching LOSS_FILTER it goes to WAIT_LOCK, with both resets asserting and ready falling on the same edge.
REQ-019 In RUN, a lock_s=1 cycle SHALL clear the loss counter; a low glitch shorter than LOSS_FILTER cycles SHALL have no output effect.
REQ-020 In HOLD or STAGGER, any lock_s=0 cycle SHALL return the FSM to WAIT_LOCK on the next edge; both resets are then 1 and the counter is cleared.
REQ-021 With pll_locked stable high from edge 0, sdram_reset SHALL fall at edge SYNC_STAGES+LOCK_FILTER+HOLD_CYCLES+1 and sys_reset exactly STAGGER_CYCLES edges later.
REQ-022 sys_reset SHALL never be 0 while sdram_reset is 1.
REQ-023 The single shared counter SHALL be $clog2(max parameter)+1 bits wide and SHALL never wrap.
REQ-024 loss_count SHALL increment by 1 on each RUN-to-WAIT_LOCK transition and hold at 255.

Reset
REQ-025 While reset=1 at a clk edge: FSM goes to WAIT_LOCK; counters and synchronizer flops go to 0; sdram_reset=1, sys_reset=1, ready=0, loss_count=0.
REQ-026 Reset asserted mid-sequence or in RUN SHALL restart the full sequence; no partial state is retained.

Configuration
REQ-027 Macro PLL_RESET_LOSS_CNT_EN defined: the loss_count port and its 8-bit saturating register exist.
REQ-028 Macro PLL_RESET_LOSS_CNT_EN undefined: the port and register are absent, and all other behaviour is identical.

Structure
REQ-029 Package pll_reset_pkg SHALL hold the FSM state enum, the default parameter constants and the loss_count width (8).
REQ-030 The synchronizer SHALL be sub-module pll_lock_sync (parameter SYNC_STAGES, synchronous reset to 0); all FSM and counters stay in pll_reset_seq.

Verification (SYNC_STAGES=2, LOCK_FILTER=4, LOSS_FILTER=2, HOLD_CYCLES=8, STAGGER_CYCLES=4)
REQ-031 Scenario 1: pll_locked high from edge 0 -> sdram_reset falls at edge 15, sys_reset falls and ready rises at edge 19.
REQ-032 Scenario 2: pll_locked toggles with a 3-high/1-low pattern for 40 cycles -> the FSM never leaves WAIT_LOCK and both resets stay 1.
REQ-033 Scenario 3: in RUN, pll_locked low for 1 cycle -> no output change; low for 2 cycles (after sync) -> both resets 1 and ready 0 on the next edge, and loss_count goes from 0 to 1.
REQ-034 Scenario 4: lock lost during STAGGER -> sdram_reset re-asserts on the edge after lock_s=0, the FSM is in WAIT_LOCK, and loss_count is unchanged.
REQ-035 Scenario 5: reset pulsed for 1 cycle while in RUN -> next edge gives sdram_reset=1, sys_reset=1, ready=0, loss_count=0; with lock still high the sequence repeats and sdram_reset falls 15 edges after reset deasserts.
REQ-036 Scenario 6: 300 forced loss events -> loss_count saturates at 255; with the macro undefined, the design elaborates without the port.

Source files
------------

// File: rtl/pll_reset_pkg.sv
// Shared types and defaults for the PLL reset sequencer.
// Holds the FSM state enum, default parameters and loss counter width.
package pll_reset_pkg;

  typedef enum logic [1:0] {
    WAIT_LOCK,
    HOLD,
    STAGGER,
    RUN
  } state_t;

  localparam int DEF_SYNC_STAGES    = 2;
  localparam int DEF_LOCK_FILTER    = 16;
  localparam int DEF_LOSS_FILTER    = 4;
  localparam int DEF_HOLD_CYCLES    = 1024;
  localparam int DEF_STAGGER_CYCLES = 64;
  localparam int LOSS_CNT_W         = 8;

  function automatic int max_of4(
    input int a,
    input int b,
    input int c,
    input int d
  );
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

endpackage

// File: rtl/pll_lock_sync.sv
// Multi-flop synchronizer bringing the async PLL lock flag into clk.
// Ports: clk, reset (sync, active-high), i_async in, o_sync = last stage.
import pll_reset_pkg::*;

module pll_lock_sync #(
  parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic clk,
  input  logic reset,
  input  logic i_async,
  output logic o_sync
);

  logic [SYNC_STAGES-1:0] r_sync;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_async};
    end
  end

  assign o_sync = r_sync[SYNC_STAGES-1];

endmodule

// File: rtl/pll_reset_seq.sv
// PLL-lock driven reset sequencer: SDRAM reset released first, system later.
// Ports: clk, reset, pll_locked (async) -> sdram_reset, sys_reset, ready,
// and loss_count when PLL_RESET_LOSS_CNT_EN is defined.
import pll_reset_pkg::*;

module pll_reset_seq #(
  parameter int SYNC_STAGES    = DEF_SYNC_STAGES,
  parameter int LOCK_FILTER    = DEF_LOCK_FILTER,
  parameter int LOSS_FILTER    = DEF_LOSS_FILTER,
  parameter int HOLD_CYCLES    = DEF_HOLD_CYCLES,
  parameter int STAGGER_CYCLES = DEF_STAGGER_CYCLES
) (
  input  logic clk,
  input  logic reset,
  input  logic pll_locked,
  output logic sdram_reset,
  output logic sys_reset,
  output logic ready
`ifdef PLL_RESET_LOSS_CNT_EN
  ,
  output logic [LOSS_CNT_W-1:0] loss_count
`endif
);

  localparam int CNT_MAX = max_of4(LOCK_FILTER, LOSS_FILTER,
                                   HOLD_CYCLES, STAGGER_CYCLES);
  localparam int CNT_W = $clog2(CNT_MAX) + 1;

  localparam logic [CNT_W-1:0] C_LOCK = CNT_W'(LOCK_FILTER);
  localparam logic [CNT_W-1:0] C_HOLD = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] C_STAG = CNT_W'(STAGGER_CYCLES - 1);
  localparam logic [CNT_W-1:0] C_LOSS = CNT_W'(LOSS_FILTER - 1);

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             w_lock_s;

  pll_lock_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk    (clk),
    .reset  (reset),
    .i_async(pll_locked),
    .o_sync (w_lock_s)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= WAIT_LOCK;
      r_cnt       <= '0;
      sdram_reset <= 1'b1;
      sys_reset   <= 1'b1;
      ready       <= 1'b0;
    end else begin
      unique case (r_state)
        WAIT_LOCK: begin
          sdram_reset <= 1'b1;
          sys_reset   <= 1'b1;
          ready       <= 1'b0;
          // Filter counts lock_s high cycles; any low cycle restarts it.
          if (!w_lock_s) begin
            r_cnt <= '0;
          end else if (r_cnt == C_LOCK) begin
            r_state <= HOLD;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        HOLD: begin
          if (!w_lock_s) begin
            r_state <= WAIT_LOCK;
            r_cnt   <= '0;
          end else if (r_cnt == C_HOLD) begin
            r_state     <= STAGGER;
            r_cnt       <= '0;
            sdram_reset <= 1'b0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        STAGGER: begin
          if (!w_lock_s) begin
            r_state     <= WAIT_LOCK;
            r_cnt       <= '0;
            sdram_reset <= 1'b1;
          end else if (r_cnt == C_STAG) begin
            r_state   <= RUN;
            r_cnt     <= '0;
            sys_reset <= 1'b0;
            ready     <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        RUN: begin
          // Short low glitches are absorbed; only a full run trips.
          if (w_lock_s) begin
            r_cnt <= '0;
          end else if (r_cnt == C_LOSS) begin
            r_state     <= WAIT_LOCK;
            r_cnt       <= '0;
            sdram_reset <= 1'b1;
            sys_reset   <= 1'b1;
            ready       <= 1'b0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: begin
          r_state <= WAIT_LOCK;
          r_cnt   <= '0;
        end
      endcase
    end
  end

`ifdef PLL_RESET_LOSS_CNT_EN
  logic w_loss_evt;

  assign w_loss_evt = (r_state == RUN) && !w_lock_s &&
                      (r_cnt == C_LOSS);

  always_ff @(posedge clk) begin
    if (reset) begin
      loss_count <= '0;
    end else if (w_loss_evt && (loss_count != '1)) begin
      loss_count <= loss_count + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_pll_reset_seq.sv
// Directed bench for pll_reset_seq with small parameters.
// Edge 0 is the last edge sampling reset=1 before the sequence runs.
module tb_pll_reset_seq;

  logic clk = 1'b0;
  logic reset;
  logic pll_locked;
  logic sdram_reset;
  logic sys_reset;
  logic ready;
`ifdef PLL_RESET_LOSS_CNT_EN
  logic [7:0] loss_count;
`endif

  int errs = 0;
  int checks = 0;

  always #5 clk = ~clk;

  pll_reset_seq #(
    .SYNC_STAGES   (2),
    .LOCK_FILTER   (4),
    .LOSS_FILTER   (2),
    .HOLD_CYCLES   (8),
    .STAGGER_CYCLES(4)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .pll_locked (pll_locked),
    .sdram_reset(sdram_reset),
    .sys_reset  (sys_reset),
    .ready      (ready)
`ifdef PLL_RESET_LOSS_CNT_EN
    ,
    .loss_count (loss_count)
`endif
  );

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d",
               tag, $signed(got), $signed(exp));
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_loss(input string tag, input int exp);
`ifdef PLL_RESET_LOSS_CNT_EN
    chk(tag, 32'(loss_count), exp);
`endif
  endtask

  task automatic wait_ready(input string tag);
    int n;
    n = 0;
    while (!ready && n < 200) begin
      tick;
      n++;
    end
    chk(tag, 32'(ready), 1);
  endtask

  // Expects lock high from edge 0 (the previous tick).
  task automatic seq_timing(input string tag);
    int t_sd;
    int t_sys;
    int t_rdy;
    int bad;
    t_sd  = -1;
    t_sys = -1;
    t_rdy = -1;
    bad   = 0;
    for (int e = 1; e <= 40; e++) begin
      tick;
      if (t_sd < 0 && !sdram_reset) t_sd = e;
      if (t_sys < 0 && !sys_reset) t_sys = e;
      if (t_rdy < 0 && ready) t_rdy = e;
      if (sdram_reset && !sys_reset) bad++;
    end
    chk({tag, " sdram_fall"}, t_sd, 15);
    chk({tag, " sys_fall"}, t_sys, 19);
    chk({tag, " ready_rise"}, t_rdy, 19);
    chk({tag, " order"}, bad, 0);
  endtask

  initial begin
    int bad;
    int n;
    reset      = 1'b1;
    pll_locked = 1'b0;
    repeat (3) tick;
    chk("rst sdram", 32'(sdram_reset), 1);
    chk("rst sys", 32'(sys_reset), 1);
    chk("rst ready", 32'(ready), 0);
    chk_loss("rst loss", 0);

    // Scenario 2: 3-high/1-low never satisfies the 4-cycle filter
    reset = 1'b0;
    bad   = 0;
    for (int i = 0; i < 40; i++) begin
      pll_locked = (i % 4) != 3;
      tick;
      if (!sdram_reset || !sys_reset || ready) bad++;
    end
    chk("s2 stuck", bad, 0);

    // Scenario 1: clean lock from edge 0
    reset      = 1'b1;
    pll_locked = 1'b0;
    tick;
    reset      = 1'b0;
    pll_locked = 1'b1;
    seq_timing("s1");

    // Scenario 3: 1-cycle glitch ignored
    pll_locked = 1'b0;
    tick;
    pll_locked = 1'b1;
    bad = 0;
    for (int i = 0; i < 6; i++) begin
      tick;
      if (!ready || sdram_reset || sys_reset) bad++;
    end
    chk("s3 glitch", bad, 0);
    chk_loss("s3 loss0", 0);

    // Scenario 3: 2-cycle loss trips back to WAIT_LOCK
    pll_locked = 1'b0;
    tick;
    tick;
    pll_locked = 1'b1;
    tick;
    chk("s3 e3 ready", 32'(ready), 1);
    tick;
    chk("s3 e4 ready", 32'(ready), 0);
    chk("s3 e4 sdram", 32'(sdram_reset), 1);
    chk("s3 e4 sys", 32'(sys_reset), 1);
    chk_loss("s3 loss1", 1);

    // Scenario 4: lose lock in STAGGER
    n = 0;
    while (sdram_reset && n < 100) begin
      tick;
      n++;
    end
    chk("s4 stagger", 32'({sdram_reset, sys_reset}), 1);
    pll_locked = 1'b0;
    tick;
    tick;
    chk("s4 e2 sdram", 32'(sdram_reset), 0);
    tick;
    chk("s4 e3 sdram", 32'(sdram_reset), 1);
    chk("s4 e3 sys", 32'(sys_reset), 1);
    chk("s4 e3 ready", 32'(ready), 0);
    chk_loss("s4 loss", 1);
    pll_locked = 1'b1;
    wait_ready("s4 relock");

    // Scenario 5: reset pulse while in RUN
    reset = 1'b1;
    tick;
    reset = 1'b0;
    chk("s5 sdram", 32'(sdram_reset), 1);
    chk("s5 sys", 32'(sys_reset), 1);
    chk("s5 ready", 32'(ready), 0);
    chk_loss("s5 loss", 0);
    seq_timing("s5");

`ifdef PLL_RESET_LOSS_CNT_EN
    // Scenario 6: saturation of the loss counter
    for (int i = 0; i < 300; i++) begin
      wait_ready("s6 ready");
      pll_locked = 1'b0;
      repeat (4) tick;
      pll_locked = 1'b1;
      if (i == 9) chk("s6 loss10", 32'(loss_count), 10);
    end
    chk("s6 sat", 32'(loss_count), 255);
`endif

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
